// File: rtl/usb4_os_detector_if.sv
// Receive-side bus of the ordered-set detector: per-lane words in, per-lane and
// combined detection status out.
interface usb4_os_detector_if #(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CNT_W     = 2
);
  logic [NUM_LANES-1:0]        rx_valid;
  logic [NUM_LANES*DATA_W-1:0] rx_data;
  logic [NUM_LANES-1:0]        lane_det;
  logic [NUM_LANES*CNT_W-1:0]  lane_cnt;
  logic                        det;

  modport master (output rx_valid, rx_data, input lane_det, lane_cnt, det);
  modport slave  (input rx_valid, rx_data, output lane_det, lane_cnt, det);
endinterface

// File: rtl/usb4_os_detector.sv
// Per-lane ordered-set detector: counts back-to-back matches of a programmable
// ordered set per lane, combines lanes (AND/OR) and flags a sticky timeout.
module usb4_os_detector #(
  parameter int unsigned NUM_LANES   = 2,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned OS_WORDS    = 4,
  parameter int unsigned REQ_COUNT   = 2,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned CNT_W       = $clog2(REQ_COUNT + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         all_lanes,
  input  logic [OS_WORDS*DATA_W-1:0]   os_pattern,
  usb4_os_detector_if.slave            bus,
  output logic                         timeout
);

  localparam int unsigned IDX_W = (OS_WORDS > 1) ? $clog2(OS_WORDS) : 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic {HUNT, COLLECT} state_t;

  state_t             state_q [NUM_LANES];
  state_t             state_d [NUM_LANES];
  logic [IDX_W-1:0]   idx_q   [NUM_LANES];
  logic [IDX_W-1:0]   idx_d   [NUM_LANES];
  logic [CNT_W-1:0]   cnt_q   [NUM_LANES];
  logic [CNT_W-1:0]   cnt_d   [NUM_LANES];
  logic [NUM_LANES-1:0] det_q;
  logic [NUM_LANES-1:0] det_d;
  logic [DATA_W-1:0]  pat     [OS_WORDS];
  logic [DATA_W-1:0]  word    [NUM_LANES];
  logic [TO_W-1:0]    to_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_W'(REQ_COUNT)) ? c : c + CNT_W'(1);
  endfunction

  always_comb begin
    for (int unsigned k = 0; k < OS_WORDS; k++) pat[k] = os_pattern[k*DATA_W +: DATA_W];
    for (int unsigned i = 0; i < NUM_LANES; i++) word[i] = bus.rx_data[i*DATA_W +: DATA_W];
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      state_d[i] = state_q[i];
      idx_d[i]   = idx_q[i];
      cnt_d[i]   = cnt_q[i];
      if (bus.rx_valid[i]) begin
        unique case (state_q[i])
          HUNT: begin
            if (word[i] == pat[0]) begin
              if (OS_WORDS == 1) begin
                cnt_d[i] = sat_inc(cnt_q[i]);
              end else begin
                state_d[i] = COLLECT;
                idx_d[i]   = IDX_W'(1);
              end
            end else begin
              cnt_d[i] = '0;
            end
          end
          COLLECT: begin
            if (word[i] == pat[idx_q[i]]) begin
              if (idx_q[i] == IDX_W'(OS_WORDS - 1)) begin
                cnt_d[i]   = sat_inc(cnt_q[i]);
                state_d[i] = HUNT;
                idx_d[i]   = '0;
              end else begin
                idx_d[i] = idx_q[i] + IDX_W'(1);
              end
            end else begin
              // a broken set still may start a new one on this very word
              cnt_d[i] = '0;
              if (word[i] == pat[0]) begin
                idx_d[i] = IDX_W'(1);
              end else begin
                state_d[i] = HUNT;
                idx_d[i]   = '0;
              end
            end
          end
          default: ;
        endcase
      end
      det_d[i] = (cnt_d[i] == CNT_W'(REQ_COUNT));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || !en) begin
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        state_q[i] <= HUNT;
        idx_q[i]   <= '0;
        cnt_q[i]   <= '0;
      end
      det_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        state_q[i] <= state_d[i];
        idx_q[i]   <= idx_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      det_q <= det_d;
    end
  end

  // counter freezes once detected or expired; det rising on the expiry edge
  // does not suppress the flag since det is the pre-edge value
  always_ff @(posedge clk) begin
    if (!rst || !en) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else if (!bus.det && !timeout) begin
      to_cnt <= to_cnt + TO_W'(1);
      if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) timeout <= 1'b1;
    end
  end

  always_comb begin
    bus.lane_cnt = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) bus.lane_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end

  assign bus.lane_det = det_q;
  assign bus.det      = all_lanes ? &det_q : |det_q;

endmodule

// File: tb/tb_usb4_os_detector.sv
// Scoreboard bench for usb4_os_detector: a queue-based reference model predicts
// every cycle's outputs; a monitor pops and compares after each clock edge.
module tb_usb4_os_detector;

  localparam int unsigned TO_CYC = 20;
  localparam int unsigned REQ    = 2;
  localparam int unsigned OSW    = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic all_lanes = 1'b1;
  logic [31:0] os_pattern = {8'h3C, 8'h2D, 8'h1E, 8'h0F};
  logic timeout;

  usb4_os_detector_if #(.NUM_LANES(2), .DATA_W(8), .CNT_W(2)) bus ();

  usb4_os_detector #(
    .NUM_LANES(2), .DATA_W(8), .OS_WORDS(OSW), .REQ_COUNT(REQ),
    .TIMEOUT_CYC(TO_CYC), .CNT_W(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .all_lanes(all_lanes),
    .os_pattern(os_pattern), .bus(bus), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  ld;
    logic [3:0]  lc;
    logic        d;
    logic        to;
    logic [15:0] tag;
  } exp_t;

  exp_t expq[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  // reference model: words collected toward the current set, per lane
  typedef logic [7:0] word_q_t[$];
  word_q_t     mbuf [2];
  logic [7:0]  pat  [4];
  logic [1:0]  mcnt [2];
  logic [1:0]  mdet;
  int unsigned nodet_cycles;
  logic        all_sel;
  logic [15:0] tag;

  task automatic step(input logic e, input logic r, input logic [1:0] v,
                      input logic [7:0] d0, input logic [7:0] d1);
    logic prev_det;
    logic [7:0] w;
    exp_t x;
    @(negedge clk);
    en = e; rst = r; all_lanes = all_sel;
    bus.rx_valid = v; bus.rx_data = {d1, d0};
    prev_det = all_sel ? &mdet : |mdet;
    for (int l = 0; l < 2; l++) begin
      if (!r || !e) begin
        mbuf[l].delete();
        mcnt[l] = 0;
      end else if (v[l]) begin
        w = (l == 0) ? d0 : d1;
        if (w == pat[mbuf[l].size()]) begin
          mbuf[l].push_back(w);
          if (mbuf[l].size() == OSW) begin
            if (mcnt[l] < 2'(REQ)) mcnt[l] = mcnt[l] + 2'd1;
            mbuf[l].delete();
          end
        end else begin
          mcnt[l] = 0;
          mbuf[l].delete();
          if (w == pat[0]) mbuf[l].push_back(w);
        end
      end
      mdet[l] = (mcnt[l] == 2'(REQ));
    end
    if (!r || !e) nodet_cycles = 0;
    else if (!prev_det) nodet_cycles++;
    x.ld = mdet;
    x.lc = {mcnt[1], mcnt[0]};
    x.d = all_sel ? &mdet : |mdet;
    x.to = (nodet_cycles >= TO_CYC);
    x.tag = tag;
    expq.push_back(x);
  endtask

  task automatic clear(input logic a);
    all_sel = a;
    step(1'b0, 1'b1, 2'b00, 8'h00, 8'h00);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b1, 2'b00, 8'h00, 8'h00);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp, input logic [15:0] t);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s tag=%0d got=%0h expected=%0h", name, t, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("lane_det", {6'd0, bus.lane_det}, {6'd0, e.ld}, e.tag);
        chk("lane_cnt", {4'd0, bus.lane_cnt}, {4'd0, e.lc}, e.tag);
        chk("det", {7'd0, bus.det}, {7'd0, e.d}, e.tag);
        chk("timeout", {7'd0, timeout}, {7'd0, e.to}, e.tag);
      end
    end
  end

  initial begin : driver
    logic [7:0] seq [10];
    logic [7:0] w [2];
    logic [1:0] v;
    int unsigned sp [2];
    int wait_n;
    pat = '{8'h0F, 8'h1E, 8'h2D, 8'h3C};
    mcnt = '{2'd0, 2'd0};
    mdet = '0;
    nodet_cycles = 0;
    all_sel = 1'b1;
    bus.rx_valid = '0;
    bus.rx_data = '0;
    sp = '{0, 0};

    tag = 0;
    all_sel = 1'b1;
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 2'b00, 8'h00, 8'h00);

    tag = 1;  // nominal, all lanes
    clear(1'b1);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 2'b11, pat[k % 4], pat[k % 4]);
    idle(4);

    tag = 2;  // any-lane mode, lane 1 idle pattern
    clear(1'b0);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 2'b11, pat[k % 4], 8'h00);
    idle(3);

    tag = 3;  // same traffic in all-lanes mode runs into the timeout
    clear(1'b1);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 2'b11, pat[k % 4], 8'h00);
    for (int k = 0; k < 16; k++) step(1'b1, 1'b1, 2'b11, 8'h00, 8'h00);

    tag = 4;  // mismatch then resync
    clear(1'b1);
    seq = '{8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h0F, 8'h1E, 8'h0F, 8'h1E, 8'h2D, 8'h3C};
    for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 2'b01, seq[k], 8'h00);
    idle(2);

    tag = 5;  // valid gaps of three cycles
    clear(1'b1);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b1, 2'b11, pat[k % 4], pat[k % 4]);
      for (int g = 0; g < 3; g++) step(1'b1, 1'b1, 2'b00, 8'hAA, 8'hAA);
    end
    idle(2);

    tag = 6;  // saturation then drop
    clear(1'b1);
    for (int k = 0; k < 12; k++) step(1'b1, 1'b1, 2'b11, pat[k % 4], pat[k % 4]);
    step(1'b1, 1'b1, 2'b11, 8'h55, 8'h55);
    idle(2);

    tag = 7;  // en dropped mid-set
    clear(1'b1);
    step(1'b1, 1'b1, 2'b11, 8'h0F, 8'h0F);
    step(1'b1, 1'b1, 2'b11, 8'h1E, 8'h1E);
    step(1'b0, 1'b1, 2'b11, 8'h2D, 8'h2D);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 2'b11, pat[k % 4], pat[k % 4]);
    idle(2);

    tag = 8;  // rst asserted mid-set
    clear(1'b1);
    step(1'b1, 1'b1, 2'b11, 8'h0F, 8'h0F);
    step(1'b1, 1'b1, 2'b11, 8'h1E, 8'h1E);
    step(1'b1, 1'b0, 2'b11, 8'h2D, 8'h2D);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 2'b11, pat[k % 4], pat[k % 4]);
    idle(2);

    tag = 9;  // randomized traffic, mostly in-pattern words
    clear(1'b1);
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        all_sel = 1'($urandom_range(0, 1));
        step(1'b0, 1'b1, 2'b00, 8'h00, 8'h00);
      end else begin
        for (int l = 0; l < 2; l++) begin
          int unsigned r;
          v[l] = ($urandom_range(0, 3) != 0);
          r = $urandom_range(0, 99);
          if (r < 82) begin
            w[l] = pat[sp[l]];
            sp[l] = (sp[l] + 1) % 4;
          end else if (r < 91) begin
            w[l] = pat[0];
            sp[l] = 1;
          end else begin
            w[l] = 8'($urandom);
            sp[l] = 0;
          end
        end
        step(1'b1, ($urandom_range(0, 299) != 0), v, w[0], w[1]);
      end
    end

    wait_n = 0;
    while (expq.size() != 0 && wait_n < 10) begin
      @(negedge clk);
      wait_n++;
    end
    if (expq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d expected=0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
